// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor.
// Contents:
//   WIDTH_DEFAULT - default operand width in bits
//   state_t       - FSM state encoding (IDLE, RUN, DONE)
package serial_sub_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_sub_pkg

// File: rtl/half_sub_mux.sv
// Mux-style half subtractor: computes x - y for single bits.
// Ports:
//   x  (in)  minuend bit; it steers both muxes
//   y  (in)  subtrahend bit
//   d  (out) difference bit: ~y when x is set, y otherwise
//   br (out) borrow bit: 0 when x is set, y otherwise
module half_sub_mux (
  input  logic x,
  input  logic y,
  output logic d,
  output logic br
);

  assign d  = x ? ~y : y;
  assign br = x ? 1'b0 : y;

endmodule : half_sub_mux

// File: rtl/serial_sub_mux.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first.
// Ports:
//   clk   (in)  clock, rising edge active
//   rst_n (in)  asynchronous active-low reset
//   start (in)  begin an operation; only looked at while idle
//   a, b  (in)  minuend / subtrahend, captured on the accepting edge
//   busy  (out) high while bits are being processed
//   done  (out) one-cycle pulse when diff/bout are valid
//   diff  (out) (a - b) mod 2^WIDTH, held until the next accepted start
//   bout  (out) final borrow, 1 when a < b unsigned
module serial_sub_mux
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] diff_r;
  logic [CW-1:0]    cnt_r;
  logic             br_r;
  logic             busy_r;
  logic             done_r;
  logic             bout_r;

  logic hs0_d_s;
  logic hs0_br_s;
  logic hs1_br_s;
  logic cell_d_s;
  logic cell_br_s;

  // First half subtractor: a_i - b_i.
  half_sub_mux u_hs0 (
    .x  (a_r[0]),
    .y  (b_r[0]),
    .d  (hs0_d_s),
    .br (hs0_br_s)
  );

  // Second half subtractor: subtract the incoming borrow from the partial difference.
  half_sub_mux u_hs1 (
    .x  (hs0_d_s),
    .y  (br_r),
    .d  (cell_d_s),
    .br (hs1_br_s)
  );

  // At most one of the two stages can borrow, so OR gives the cell borrow.
  assign cell_br_s = hs0_br_s | hs1_br_s;

  // Control FSM, operand shifters, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      diff_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      br_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            diff_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            br_r    <= 1'b0;
            bout_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          // Operands move toward bit 0; result bits enter from the MSB side
          // so that after WIDTH shifts bit 0 of the result sits at diff[0].
          a_r    <= {1'b0, a_r[WIDTH-1:1]};
          b_r    <= {1'b0, b_r[WIDTH-1:1]};
          diff_r <= {cell_d_s, diff_r[WIDTH-1:1]};
          br_r   <= cell_br_s;
          if (cnt_r == LAST_BIT) begin
            bout_r  <= cell_br_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;

endmodule : serial_sub_mux

// File: tb/tb_serial_sub_mux.sv
// Self-checking bench for serial_sub_mux (WIDTH = 8) against an
// arithmetic reference: diff = (a - b) mod 256, bout = (a < b).
module tb_serial_sub_mux;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_cmp = 0;
  int n_bad = 0;

  serial_sub_mux #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_diff(input int unsigned x, input int unsigned y);
    ref_diff = W'((x + 256 - y) % 256);
  endfunction

  function automatic logic ref_bout(input int unsigned x, input int unsigned y);
    ref_bout = (x < y) ? 1'b1 : 1'b0;
  endfunction

  // One full operation; optional noise on start/a/b while it runs.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit noise);
    int j;
    int busy_cnt;
    logic [W-1:0] got_d;
    logic got_b;
    @(negedge clk);
    a = xa; b = xb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    j = 0; busy_cnt = 0;
    while (j < 40) begin
      if (busy) busy_cnt++;
      if (busy && done) check_eq("busy_and_done", 1, 0);
      if (done) break;
      @(posedge clk); #1;
      j++;
      if (noise) begin
        start = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end
    end
    start = 1'b0;
    check_eq("done_seen", done, 1);
    check_eq("latency", j, W);
    check_eq("busy_cycles", busy_cnt, W);
    got_d = diff; got_b = bout;
    check_eq("diff", got_d, ref_diff(xa, xb));
    check_eq("bout", got_b, ref_bout(xa, xb));
    @(posedge clk); #1;
    check_eq("done_single", done, 0);
    check_eq("diff_hold", diff, ref_diff(xa, xb));
    check_eq("bout_hold", bout, ref_bout(xa, xb));
  endtask

  initial begin : main
    logic [W-1:0] opa [30];
    logic [W-1:0] opb [30];
    int done_edge [$];
    logic [W-1:0] done_diff [$];
    logic done_bout [$];
    int acc0;
    int acc1;

    // Reset state.
    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_diff", diff, 0);
    check_eq("rst_bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    do_op(8'd5, 8'd3, 1'b0);
    do_op(8'd3, 8'd5, 1'b0);
    do_op(8'd0, 8'd1, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b0);
    do_op(8'hA5, 8'h00, 1'b0);

    // start held high for 20 cycles with changing operands.
    for (int e = 0; e < 30; e++) begin
      opa[e] = W'($urandom);
      opb[e] = W'($urandom);
    end
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      a = opa[e]; b = opb[e]; start = (e < 20);
      @(posedge clk); #1;
      if (done) begin
        done_edge.push_back(e);
        done_diff.push_back(diff);
        done_bout.push_back(bout);
      end
    end
    start = 1'b0;
    // Accepts at edge 0; next accept one edge after returning to IDLE.
    acc0 = 0;
    acc1 = acc0 + W + 2;
    check_eq("hold_ops", done_edge.size(), 2);
    if (done_edge.size() == 2) begin
      check_eq("hold_done0_edge", done_edge[0], acc0 + W);
      check_eq("hold_done1_edge", done_edge[1], acc1 + W);
      check_eq("hold_diff0", done_diff[0], ref_diff(opa[acc0], opb[acc0]));
      check_eq("hold_bout0", done_bout[0], ref_bout(opa[acc0], opb[acc0]));
      check_eq("hold_diff1", done_diff[1], ref_diff(opa[acc1], opb[acc1]));
      check_eq("hold_bout1", done_bout[1], ref_bout(opa[acc1], opb[acc1]));
    end

    // Reset 4 cycles into RUN.
    @(negedge clk);
    a = 8'd77; b = 8'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_diff", diff, 0);
    check_eq("abort_bout", bout, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      check_eq("abort_no_done", done, 0);
      check_eq("abort_no_busy", busy, 0);
    end
    do_op(8'd100, 8'd1, 1'b0);

    // Random sweep, with start/operand noise during half of the runs.
    for (int i = 0; i < 200; i++) begin
      do_op(W'($urandom), W'($urandom), (i % 2) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_serial_sub_mux
